// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch_entry_t with flush; head is presented combinationally
// and reads as zero while empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_head] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch initiator: PC, redirect priority, prefetch FIFO to decode.
// Optional macro FETCH_BOUNDS_CHECK_EN halts fetch past MEM_WORDS with a sticky fault.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MEM_WORDS  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(MEM_WORDS * 4);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_entry;
    logic            w_valid;
    logic            w_pop;
    logic            w_room;
    logic            w_oob;
    logic            w_halted;
    logic            w_want;
    logic            w_push;
    logic [XLEN-1:0] w_target;

    assign w_valid  = (w_count != '0);
    assign w_pop    = w_valid && instr_ready;
    assign w_room   = (w_count < CW'(FIFO_DEPTH)) || w_pop;
    assign w_oob    = (r_pc >= PC_LIMIT);
    assign w_want   = !redirect_valid && !w_halted && w_room;
    assign w_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_BOUNDS_CHECK_EN
    logic r_fault;

    assign w_push   = w_want && !w_oob;
    assign w_halted = r_fault;

    // Sticky until a redirect gives the core somewhere valid to go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_fault <= 1'b0;
        end else if (w_want && w_oob) begin
            r_fault <= 1'b1;
        end
    end

    assign fetch_fault = r_fault;
`else
    logic w_unused_oob;

    assign w_push       = w_want;
    assign w_halted     = 1'b0;
    assign w_unused_oob = w_oob;
    assign fetch_fault  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_target;
        end else if (w_push) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign w_entry = '{pc: r_pc, instr: imem_data};

    fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_entry (w_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign imem_addr   = r_pc;
    assign instr_valid = w_valid;
    assign instr_data  = w_head.instr;
    assign instr_pc    = w_head.pc;

endmodule
